fft_axi_lite_slave_regs: RTL and testbench
==========================================

# fft_axi_lite_slave_regs

AXI4-Lite slave register file that terminates the S00_AXI control port of the FFT AXI IP. It responds to the master issuing single-beat writes and reads to four 32-bit registers at offsets 0x0/0x4/0x8/0xC. Register contents are exported to the FFT datapath as control words, together with per-register write pulses.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, address width; bits [3:2] select the register, bits [1:0] are ignored.
- ACLK  in  1  single clock; all logic on the rising edge.
- ARESET  in  1  reset; asynchronous, active-high.
- S_AXI_AWADDR  in  4  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  write-address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID / S_AXI_WREADY  in/out  1  write-data handshake.
- S_AXI_BRESP  out  2  write response; always 2'b00 (OKAY).
- S_AXI_BVALID / S_AXI_BREADY  out/in  1  write-response handshake.
- S_AXI_ARADDR  in  4  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  read-address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response; always 2'b00.
- S_AXI_RVALID / S_AXI_RREADY  out/in  1  read-data handshake.
- reg0_out..reg3_out  out  32 each  current register contents.
- reg_wr_pulse  out  4  one-hot, one-cycle pulse for the register written.

## Operation
- Reset (asynchronous assert): registers = 0, RDATA = 0, BVALID = RVALID = 0, reg_wr_pulse = 0, internal aw_held/w_held flags = 0. All READY outputs are forced to 0 while ARESET = 1.
- Write channel, with AW and W independent and arriving in either order:
  - AWREADY = !aw_held && !BVALID.
  - WREADY = !w_held && !BVALID.
  - An AW handshake with no W available latches the address and sets aw_held.
  - A W handshake with no AW available latches data and strobe and sets w_held.
  - Commit edge: the first edge where an address (held or handshaking) and data (held or handshaking) are both available. On that edge:
    - bytes of reg[addr[3:2]] with WSTRB = 1 are updated; other bytes are unchanged;
    - both held flags clear;
    - BVALID is set;
    - reg_wr_pulse[addr[3:2]] is set for exactly one cycle.
  - BVALID holds until the BREADY edge. No new AW or W is accepted while BVALID = 1.
- Read channel:
  - ARREADY = !RVALID.
  - On an AR handshake, RDATA <= reg[ARADDR[3:2]] and RVALID <= 1.
  - RDATA and RVALID are stable until the RREADY edge, then RVALID clears.
- Read and write are fully independent and may be in flight simultaneously.
- A read handshake on the same edge as a write commit to the same register returns the pre-write value.
- The address map wraps: 0x10 is not reachable with 4-bit addresses, and every address decodes to a register. No SLVERR is ever returned.

## Timing
- Write latency: AW and W handshake together on edge N -> BVALID = 1 in cycle N+1. BREADY already high at the first edge with BVALID = 1 -> BVALID clears and AWREADY/WREADY return high in cycle N+2. Minimum is 2 cycles per write.
- Split write: AW on edge N, W on edge M > N -> commit on edge M, BVALID in M+1. The reverse order is symmetric.
- Read latency: AR on edge N -> RVALID and RDATA valid in N+1. With RREADY high, ARREADY returns high in N+2. Sustained rate is one read per 2 cycles.
- reg_wr_pulse is coincident with the first BVALID cycle. regN_out shows the new value in that same cycle.
- Reset mid-transaction aborts all pending state immediately: held AW/W are discarded, BVALID and RVALID drop, and registers clear. After deassertion, READY signals rise combinationally in the first cycle.

## Test plan
- Sequential write/read:
  - write 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC, each with BRESP = OKAY;
  - read back 0x0..0xC -> 0x00000001..0x00000004, each with RRESP = OKAY;
  - reg_wr_pulse = 0001, 0010, 0100, 1000 in turn.
- Byte strobes: reg1 = 0xAABBCCDD; write 0x11223344 with WSTRB = 4'b0101 -> read reg1 = 0xAA22CC44.
- Channel ordering:
  - W presented 3 cycles before AW -> BVALID exactly 1 cycle after the AW handshake, correct data written;
  - repeat with AW first, then W.
- Backpressure:
  - BREADY held low 5 cycles -> BVALID stays high, AWREADY/WREADY stay 0, a second AW is not accepted;
  - RREADY held low 5 cycles -> RDATA stable, ARREADY = 0.
- Read/write collision: reg2 = 0x5; AR to 0x8 on the same edge as a write commit of 0x9 to 0x8 -> RDATA = 0x5, subsequent read = 0x9.
- Reset mid-operation: assert ARESET while BVALID = 1 and a read is pending -> BVALID = RVALID = 0 and all regN_out = 0 immediately; the first transaction after release completes normally.

Source files
------------

// File: rtl/fft_axi_lite_slave_regs.sv
// AXI4-Lite slave with four 32-bit control registers for the FFT datapath.
// AW and W may arrive in either order; each register write raises a one-cycle pulse.
module fft_axi_lite_slave_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg0_out,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg1_out,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg2_out,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg3_out,
    output logic [3:0]                      reg_wr_pulse
);

    localparam int NUM_BYTES = C_S_AXI_DATA_WIDTH / 8;

    logic [C_S_AXI_DATA_WIDTH-1:0] regs [4];

    logic                          aw_held;
    logic [1:0]                    aw_idx_q;
    logic                          w_held;
    logic [C_S_AXI_DATA_WIDTH-1:0] w_data_q;
    logic [NUM_BYTES-1:0]          w_strb_q;
    logic                          bvalid;
    logic [3:0]                    wr_pulse;

    logic                          rvalid;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata;

    logic                          aw_hs;
    logic                          w_hs;
    logic                          ar_hs;
    logic                          commit;
    logic [1:0]                    commit_idx;
    logic [C_S_AXI_DATA_WIDTH-1:0] commit_data;
    logic [NUM_BYTES-1:0]          commit_strb;
    logic [C_S_AXI_DATA_WIDTH-1:0] merged;

    // Handshake rule on every channel: a transfer happens on the rising edge
    // where VALID and READY are both 1; VALID never waits on READY, and a
    // slave VALID once raised stays up with stable payload until that edge.
    assign S_AXI_AWREADY = !ARESET && !aw_held && !bvalid;
    assign S_AXI_WREADY  = !ARESET && !w_held  && !bvalid;
    assign S_AXI_ARREADY = !ARESET && !rvalid;

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

    // A write commits on the first edge where both an address and data are
    // present, whether each was latched earlier or is handshaking right now.
    assign commit      = (aw_held || aw_hs) && (w_held || w_hs);
    assign commit_idx  = aw_held ? aw_idx_q : S_AXI_AWADDR[3:2];
    assign commit_data = w_held  ? w_data_q : S_AXI_WDATA;
    assign commit_strb = w_held  ? w_strb_q : S_AXI_WSTRB;

    always_comb begin
        merged = regs[commit_idx];
        for (int b = 0; b < NUM_BYTES; b++) begin
            if (commit_strb[b]) begin
                merged[b*8 +: 8] = commit_data[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
            aw_held  <= 1'b0;
            aw_idx_q <= 2'b00;
            w_held   <= 1'b0;
            w_data_q <= '0;
            w_strb_q <= '0;
            bvalid   <= 1'b0;
            wr_pulse <= 4'b0000;
        end else begin
            wr_pulse <= 4'b0000;
            if (commit) begin
                regs[commit_idx] <= merged;
                aw_held          <= 1'b0;
                w_held           <= 1'b0;
                bvalid           <= 1'b1;
                wr_pulse         <= 4'b0001 << commit_idx;
            end else begin
                if (aw_hs) begin
                    aw_held  <= 1'b1;
                    aw_idx_q <= S_AXI_AWADDR[3:2];
                end
                if (w_hs) begin
                    w_held   <= 1'b1;
                    w_data_q <= S_AXI_WDATA;
                    w_strb_q <= S_AXI_WSTRB;
                end
                if (bvalid && S_AXI_BREADY) begin
                    bvalid <= 1'b0;
                end
            end
        end
    end

    // Reads sample regs before this edge's write lands, so a colliding read
    // returns the old value.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else if (ar_hs) begin
            rvalid <= 1'b1;
            rdata  <= regs[S_AXI_ARADDR[3:2]];
        end else if (rvalid && S_AXI_RREADY) begin
            rvalid <= 1'b0;
        end
    end

    assign S_AXI_BVALID = bvalid;
    assign S_AXI_BRESP  = 2'b00;
    assign S_AXI_RVALID = rvalid;
    assign S_AXI_RDATA  = rdata;
    assign S_AXI_RRESP  = 2'b00;

    assign reg0_out     = regs[0];
    assign reg1_out     = regs[1];
    assign reg2_out     = regs[2];
    assign reg3_out     = regs[3];
    assign reg_wr_pulse = wr_pulse;

    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_fft_axi_lite_slave_regs.sv
// Directed bench for fft_axi_lite_slave_regs: register model for writes,
// expected-read queue popped when the read data channel completes.
module tb_fft_axi_lite_slave_regs;

    logic        ACLK;
    logic        ARESET;
    logic [3:0]  S_AXI_AWADDR;
    logic [2:0]  S_AXI_AWPROT;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [3:0]  S_AXI_ARADDR;
    logic [2:0]  S_AXI_ARPROT;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;
    logic [31:0] reg0_out;
    logic [31:0] reg1_out;
    logic [31:0] reg2_out;
    logic [31:0] reg3_out;
    logic [3:0]  reg_wr_pulse;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model [4];

    fft_axi_lite_slave_regs #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(4)
    ) dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWPROT  (S_AXI_AWPROT),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARPROT  (S_AXI_ARPROT),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .reg0_out      (reg0_out),
        .reg1_out      (reg1_out),
        .reg2_out      (reg2_out),
        .reg3_out      (reg3_out),
        .reg_wr_pulse  (reg_wr_pulse)
    );

    // clock / watchdog
    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // check and driver tasks
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    function automatic logic [31:0] reg_out(input logic [1:0] idx);
        case (idx)
            2'd0:    return reg0_out;
            2'd1:    return reg1_out;
            2'd2:    return reg2_out;
            default: return reg3_out;
        endcase
    endfunction

    function automatic logic [31:0] apply_strb(input logic [31:0] old, input logic [31:0] d,
                                               input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        end
        return r;
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        logic [3:0] r;
        r = 4'b0000;
        r[idx] = 1'b1;
        return r;
    endfunction

    task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] expv;
        expv = apply_strb(model[a[3:2]], d, s);
        S_AXI_AWADDR  = a;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA   = d;
        S_AXI_WSTRB   = s;
        S_AXI_WVALID  = 1'b1;
        S_AXI_BREADY  = 1'b1;
        chk("wr_awready", {31'b0, S_AXI_AWREADY}, 32'd1);
        chk("wr_wready", {31'b0, S_AXI_WREADY}, 32'd1);
        tick();
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        model[a[3:2]] = expv;
        chk("wr_bvalid", {31'b0, S_AXI_BVALID}, 32'd1);
        chk("wr_bresp", {30'b0, S_AXI_BRESP}, 32'd0);
        chk("wr_pulse", {28'b0, reg_wr_pulse}, {28'b0, onehot(a[3:2])});
        chk("wr_regout", reg_out(a[3:2]), expv);
        tick();
        chk("wr_bvalid_clr", {31'b0, S_AXI_BVALID}, 32'd0);
        chk("wr_pulse_clr", {28'b0, reg_wr_pulse}, 32'd0);
    endtask

    task automatic do_read(input logic [3:0] a);
        S_AXI_ARADDR  = a;
        S_AXI_ARVALID = 1'b1;
        S_AXI_RREADY  = 1'b1;
        exp_q.push_back(model[a[3:2]]);
        chk("rd_arready", {31'b0, S_AXI_ARREADY}, 32'd1);
        tick();
        S_AXI_ARVALID = 1'b0;
        chk("rd_rvalid", {31'b0, S_AXI_RVALID}, 32'd1);
        tick();
        chk("rd_rvalid_clr", {31'b0, S_AXI_RVALID}, 32'd0);
        chk("rd_arready_back", {31'b0, S_AXI_ARREADY}, 32'd1);
    endtask

    // scoreboard: pop one expected word per completed read beat
    always @(negedge ACLK) begin
        if (!ARESET && S_AXI_RVALID && S_AXI_RREADY) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL rd_unexpected observed=%h expected=none", S_AXI_RDATA);
            end else begin
                chk("rd_data", S_AXI_RDATA, exp_q.pop_front());
                chk("rd_rresp", {30'b0, S_AXI_RRESP}, 32'd0);
            end
        end
    end

    // directed sequence
    initial begin
        ARESET        = 1'b1;
        S_AXI_AWADDR  = '0;
        S_AXI_AWPROT  = '0;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA   = '0;
        S_AXI_WSTRB   = '0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_BREADY  = 1'b0;
        S_AXI_ARADDR  = '0;
        S_AXI_ARPROT  = '0;
        S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY  = 1'b0;
        for (int i = 0; i < 4; i++) model[i] = '0;

        repeat (3) tick();
        chk("rst_bvalid", {31'b0, S_AXI_BVALID}, 32'd0);
        chk("rst_rvalid", {31'b0, S_AXI_RVALID}, 32'd0);
        chk("rst_rdata", S_AXI_RDATA, 32'd0);
        chk("rst_pulse", {28'b0, reg_wr_pulse}, 32'd0);
        chk("rst_awready", {31'b0, S_AXI_AWREADY}, 32'd0);
        chk("rst_wready", {31'b0, S_AXI_WREADY}, 32'd0);
        chk("rst_arready", {31'b0, S_AXI_ARREADY}, 32'd0);
        for (int i = 0; i < 4; i++) chk("rst_reg", reg_out(2'(i)), 32'd0);
        ARESET = 1'b0;
        #1;
        chk("rel_awready", {31'b0, S_AXI_AWREADY}, 32'd1);
        chk("rel_wready", {31'b0, S_AXI_WREADY}, 32'd1);
        chk("rel_arready", {31'b0, S_AXI_ARREADY}, 32'd1);

        // sequential write then read-back
        do_write(4'h0, 32'h1, 4'hF);
        do_write(4'h4, 32'h2, 4'hF);
        do_write(4'h8, 32'h3, 4'hF);
        do_write(4'hC, 32'h4, 4'hF);
        do_read(4'h0);
        do_read(4'h4);
        do_read(4'h8);
        do_read(4'hC);
        do_read(4'hF);

        // byte strobes
        do_write(4'h4, 32'hAABBCCDD, 4'hF);
        do_write(4'h4, 32'h11223344, 4'b0101);
        chk("strb_reg1", reg1_out, 32'hAA22CC44);
        do_read(4'h4);

        // W three cycles ahead of AW
        S_AXI_BREADY = 1'b1;
        S_AXI_WDATA  = 32'h0BAD_F00D;
        S_AXI_WSTRB  = 4'hF;
        S_AXI_WVALID = 1'b1;
        tick();
        S_AXI_WVALID = 1'b0;
        chk("wfirst_wready", {31'b0, S_AXI_WREADY}, 32'd0);
        chk("wfirst_awready", {31'b0, S_AXI_AWREADY}, 32'd1);
        chk("wfirst_bvalid", {31'b0, S_AXI_BVALID}, 32'd0);
        tick();
        tick();
        chk("wfirst_bvalid_wait", {31'b0, S_AXI_BVALID}, 32'd0);
        S_AXI_AWADDR  = 4'h8;
        S_AXI_AWVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0;
        model[2] = 32'h0BAD_F00D;
        chk("wfirst_bvalid_set", {31'b0, S_AXI_BVALID}, 32'd1);
        chk("wfirst_pulse", {28'b0, reg_wr_pulse}, 32'b0100);
        chk("wfirst_reg2", reg2_out, 32'h0BAD_F00D);
        tick();
        chk("wfirst_bvalid_clr", {31'b0, S_AXI_BVALID}, 32'd0);
        chk("wfirst_wready_back", {31'b0, S_AXI_WREADY}, 32'd1);

        // AW three cycles ahead of W
        S_AXI_AWADDR  = 4'h0;
        S_AXI_AWVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0;
        chk("awfirst_awready", {31'b0, S_AXI_AWREADY}, 32'd0);
        chk("awfirst_wready", {31'b0, S_AXI_WREADY}, 32'd1);
        chk("awfirst_bvalid", {31'b0, S_AXI_BVALID}, 32'd0);
        tick();
        tick();
        S_AXI_WDATA  = 32'h1234_5678;
        S_AXI_WSTRB  = 4'hF;
        S_AXI_WVALID = 1'b1;
        tick();
        S_AXI_WVALID = 1'b0;
        model[0] = 32'h1234_5678;
        chk("awfirst_bvalid_set", {31'b0, S_AXI_BVALID}, 32'd1);
        chk("awfirst_pulse", {28'b0, reg_wr_pulse}, 32'b0001);
        chk("awfirst_reg0", reg0_out, 32'h1234_5678);
        tick();
        chk("awfirst_bvalid_clr", {31'b0, S_AXI_BVALID}, 32'd0);
        do_read(4'h0);
        do_read(4'h8);

        // write-response backpressure; a second AW must not be taken
        S_AXI_BREADY  = 1'b0;
        S_AXI_AWADDR  = 4'hC;
        S_AXI_WDATA   = 32'hDEAD_BEEF;
        S_AXI_WSTRB   = 4'hF;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        tick();
        S_AXI_WVALID  = 1'b0;
        S_AXI_AWADDR  = 4'h0;
        model[3] = 32'hDEAD_BEEF;
        chk("bp_bvalid", {31'b0, S_AXI_BVALID}, 32'd1);
        chk("bp_pulse", {28'b0, reg_wr_pulse}, 32'b1000);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_bvalid_hold", {31'b0, S_AXI_BVALID}, 32'd1);
            chk("bp_awready", {31'b0, S_AXI_AWREADY}, 32'd0);
            chk("bp_wready", {31'b0, S_AXI_WREADY}, 32'd0);
            chk("bp_pulse_low", {28'b0, reg_wr_pulse}, 32'd0);
        end
        S_AXI_AWVALID = 1'b0;
        S_AXI_BREADY  = 1'b1;
        tick();
        chk("bp_bvalid_clr", {31'b0, S_AXI_BVALID}, 32'd0);
        chk("bp_aw_not_held", {31'b0, S_AXI_AWREADY}, 32'd1);
        chk("bp_wready_back", {31'b0, S_AXI_WREADY}, 32'd1);
        do_read(4'hC);

        // read-data backpressure
        S_AXI_RREADY  = 1'b0;
        S_AXI_ARADDR  = 4'h4;
        S_AXI_ARVALID = 1'b1;
        exp_q.push_back(model[1]);
        tick();
        S_AXI_ARVALID = 1'b0;
        chk("rbp_rvalid", {31'b0, S_AXI_RVALID}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("rbp_rdata_stable", S_AXI_RDATA, 32'hAA22CC44);
            chk("rbp_arready", {31'b0, S_AXI_ARREADY}, 32'd0);
            tick();
        end
        chk("rbp_rvalid_hold", {31'b0, S_AXI_RVALID}, 32'd1);
        S_AXI_RREADY = 1'b1;
        tick();
        chk("rbp_rvalid_clr", {31'b0, S_AXI_RVALID}, 32'd0);

        // read and write commit to the same register on the same edge
        do_write(4'h8, 32'h5, 4'hF);
        S_AXI_AWADDR  = 4'h8;
        S_AXI_WDATA   = 32'h9;
        S_AXI_WSTRB   = 4'hF;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        S_AXI_ARADDR  = 4'h8;
        S_AXI_ARVALID = 1'b1;
        S_AXI_RREADY  = 1'b1;
        exp_q.push_back(32'h5);
        tick();
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_ARVALID = 1'b0;
        model[2] = 32'h9;
        chk("col_bvalid", {31'b0, S_AXI_BVALID}, 32'd1);
        chk("col_rvalid", {31'b0, S_AXI_RVALID}, 32'd1);
        chk("col_reg2", reg2_out, 32'h9);
        tick();
        do_read(4'h8);

        // short random sweep against the model
        for (int i = 0; i < 6; i++) begin
            do_write(4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
            do_read(4'($urandom_range(0, 15)));
        end

        // reset with a write response and a read both outstanding
        S_AXI_BREADY  = 1'b0;
        S_AXI_RREADY  = 1'b0;
        S_AXI_AWADDR  = 4'h4;
        S_AXI_WDATA   = 32'h7777_7777;
        S_AXI_WSTRB   = 4'hF;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        S_AXI_ARADDR  = 4'h0;
        S_AXI_ARVALID = 1'b1;
        exp_q.push_back(model[0]);
        tick();
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_ARVALID = 1'b0;
        chk("mrst_pre_bvalid", {31'b0, S_AXI_BVALID}, 32'd1);
        chk("mrst_pre_rvalid", {31'b0, S_AXI_RVALID}, 32'd1);
        ARESET = 1'b1;
        #1;
        exp_q.delete();
        for (int i = 0; i < 4; i++) model[i] = '0;
        chk("mrst_bvalid", {31'b0, S_AXI_BVALID}, 32'd0);
        chk("mrst_rvalid", {31'b0, S_AXI_RVALID}, 32'd0);
        chk("mrst_awready", {31'b0, S_AXI_AWREADY}, 32'd0);
        chk("mrst_arready", {31'b0, S_AXI_ARREADY}, 32'd0);
        for (int i = 0; i < 4; i++) chk("mrst_reg", reg_out(2'(i)), 32'd0);
        tick();
        tick();
        ARESET = 1'b0;
        #1;
        chk("mrst_rel_awready", {31'b0, S_AXI_AWREADY}, 32'd1);
        chk("mrst_rel_arready", {31'b0, S_AXI_ARREADY}, 32'd1);
        do_write(4'h4, 32'hCAFE_0001, 4'hF);
        do_read(4'h4);
        do_read(4'h0);

        tick();
        chk("sb_queue_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
